// File: rtl/sha_msg_schedule.sv
// SHA message-schedule expander: takes one 16-word block and streams W_0..W_{N-1}
// from a 16-word sliding window, SHA-1 / SHA-224/256 / SHA-384/512.
package sha;
  typedef logic [63:0]   word_t;
  typedef logic [1023:0] msg_t;

  typedef enum logic [2:0] {
    SHA1   = 3'd0,
    SHA224 = 3'd1,
    SHA256 = 3'd2,
    SHA384 = 3'd3,
    SHA512 = 3'd4
  } mode_t;

  function automatic logic [31:0] delta0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] delta1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [63:0] delta0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] delta1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction
endpackage

module sha_msg_schedule
  import sha::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  msg_t       msg,
  input  mode_t      mode,
  output logic       w_valid,
  input  logic       w_ready,
  output word_t      w,
  output logic [6:0] w_round,
  output logic       w_last,
  output logic       mode_err
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready and the payload is held while valid & ~ready.

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  word_t [15:0]    win_q, win_d;
  logic  [6:0]     round_q, round_d;
  mode_t           mode_q, mode_d;
  logic            mode_err_q, mode_err_d;

  logic  [6:0]     last_idx;
  logic            load_is64;
  logic  [31:0]    sha1_x;
  logic  [31:0]    sum32;
  logic  [63:0]    sum64;
  word_t           next_w;

  assign last_idx  = (mode_q == SHA224 || mode_q == SHA256) ? 7'd63 : 7'd79;
  assign load_is64 = (mode == SHA384) || (mode == SHA512);

  // Next window word W_{t+16}, computed from the window holding W_t..W_{t+15}.
  always_comb begin
    sha1_x = win_q[13][31:0] ^ win_q[8][31:0] ^ win_q[2][31:0] ^ win_q[0][31:0];
    sum32  = delta1_32(win_q[14][31:0]) + win_q[9][31:0]
           + delta0_32(win_q[1][31:0]) + win_q[0][31:0];
    sum64  = delta1_64(win_q[14]) + win_q[9] + delta0_64(win_q[1]) + win_q[0];
    case (mode_q)
      SHA1:           next_w = {32'h0, sha1_x[30:0], sha1_x[31]};
      SHA224, SHA256: next_w = {32'h0, sum32};
      default:        next_w = sum64;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    round_d    = round_q;
    mode_d     = mode_q;
    mode_err_d = 1'b0;
    msg_ready  = (state_q == IDLE) && !rst;
    w_valid    = (state_q == RUN);
    w          = (state_q == RUN) ? win_q[0] : '0;
    w_round    = round_q;
    w_last     = (state_q == RUN) && (round_q == last_idx);

    case (state_q)
      IDLE: begin
        if (msg_valid && msg_ready) begin
          if (3'(mode) <= 3'd4) begin
            for (int j = 0; j < 16; j++) begin
              if (load_is64) win_d[j] = msg[1023 - 64*j -: 64];
              else           win_d[j] = {32'h0, msg[511 - 32*j -: 32]};
            end
            mode_d  = mode;
            round_d = 7'd0;
            state_d = RUN;
          end else begin
            mode_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (w_ready) begin
          win_d = {next_w, win_q[15:1]};
          if (w_last) begin
            round_d = 7'd0;
            state_d = IDLE;
          end else begin
            round_d = round_q + 7'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mode_err = mode_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      round_q    <= 7'd0;
      mode_q     <= SHA1;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      round_q    <= round_d;
      mode_q     <= mode_d;
      mode_err_q <= mode_err_d;
    end
  end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Bench for sha_msg_schedule: directed blocks, a textbook W_t reference model feeding
// an expected queue, and a monitor that pops and compares every transferred word.
module tb_sha_msg_schedule;
  import sha::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       msg_valid;
  logic       msg_ready;
  msg_t       msg;
  mode_t      mode;
  logic       w_valid;
  logic       w_ready;
  word_t      w;
  logic [6:0] w_round;
  logic       w_last;
  logic       mode_err;

  sha_msg_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg       (msg),
    .mode      (mode),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w         (w),
    .w_round   (w_round),
    .w_last    (w_last),
    .mode_err  (mode_err)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [63:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_t = 0;
  int          cur_n = 0;
  int          acc_cyc = 0;
  logic [63:0] got [0:79];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // reference model, standard W_t indexing
  function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic push_expected(input msg_t m, input logic [2:0] md);
    logic [63:0] ww [0:79];
    logic [31:0] a, b, c;
    logic [63:0] d, e;
    int n;
    n = (md == 3'd1 || md == 3'd2) ? 64 : 80;
    for (int t = 0; t < 16; t++) begin
      if (md >= 3'd3) ww[t] = m[1023 - 64*t -: 64];
      else            ww[t] = {32'h0, m[511 - 32*t -: 32]};
    end
    for (int t = 16; t < 80; t++) begin
      if (md == 3'd0) begin
        a = ww[t-3][31:0] ^ ww[t-8][31:0] ^ ww[t-14][31:0] ^ ww[t-16][31:0];
        ww[t] = {32'h0, rr32(a, 31)};
      end else if (md <= 3'd2) begin
        b = rr32(ww[t-2][31:0], 17) ^ rr32(ww[t-2][31:0], 19) ^ (ww[t-2][31:0] >> 10);
        c = rr32(ww[t-15][31:0], 7) ^ rr32(ww[t-15][31:0], 18) ^ (ww[t-15][31:0] >> 3);
        a = b + ww[t-7][31:0] + c + ww[t-16][31:0];
        ww[t] = {32'h0, a};
      end else begin
        d = rr64(ww[t-2], 19) ^ rr64(ww[t-2], 61) ^ (ww[t-2] >> 6);
        e = rr64(ww[t-15], 1) ^ rr64(ww[t-15], 8) ^ (ww[t-15] >> 7);
        ww[t] = d + ww[t-7] + e + ww[t-16];
      end
    end
    for (int t = 0; t < n; t++) exp_q.push_back(ww[t]);
    cur_n = n;
    exp_t = 0;
  endtask

  // monitor: every transfer is popped and checked
  always @(negedge clk) begin
    if (!rst && w_valid && w_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_word: observed w=0x%h round=%0d expected no transfer", w, w_round);
      end
      if (exp_q.size() != 0) begin
        check("w", w, exp_q.pop_front());
        check("w_round", 64'(w_round), 64'(exp_t));
        check("w_last", 64'(w_last), 64'(exp_t == cur_n - 1));
        // W_0 must be presented in the cycle right after the accept edge
        if (exp_t == 0) check("latency", 64'(cyc - acc_cyc), 64'd0);
        if (exp_t < 80) got[exp_t] = w;
        exp_t++;
      end
    end
  end

  // driver tasks
  task automatic send_block(input msg_t m, input logic [2:0] md);
    int i;
    @(negedge clk);
    msg       = m;
    mode      = mode_t'(md);
    msg_valid = 1'b1;
    for (i = 0; i < 200; i++) begin
      if (msg_ready) break;
      @(negedge clk);
    end
    check("accept_timeout", 64'(msg_ready), 64'd1);
    push_expected(m, md);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    msg_valid = 1'b0;
    // block contents and mode must be ignored once accepted
    msg       = {32{$urandom()}};
    mode      = mode_t'(3'd7);
  endtask

  task automatic wait_idle(output int elapsed);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (msg_ready && exp_q.size() == 0) break;
    end
    check("idle_reached", 64'(msg_ready), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    elapsed = cyc - acc_cyc;
  endtask

  task automatic wait_round(input int r);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (w_valid && int'(w_round) == r) break;
    end
    check("reach_round", 64'(w_round), 64'(r));
  endtask

  msg_t        abc32, abc64, rnd;
  int          el;
  logic [63:0] held;

  initial begin
    rst       = 1'b1;
    msg_valid = 1'b0;
    w_ready   = 1'b1;
    msg       = '0;
    mode      = SHA256;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", 64'(msg_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_w_valid", 64'(w_valid), 64'd0);
    check("rst_w", w, 64'd0);
    check("rst_w_round", 64'(w_round), 64'd0);
    check("rst_w_last", 64'(w_last), 64'd0);
    check("rst_mode_err", 64'(mode_err), 64'd0);
    check("rst_msg_ready", 64'(msg_ready), 64'd1);

    abc32 = '0;
    abc32[1023:512] = {16{$urandom()}};
    abc32[511:480]  = 32'h61626380;
    abc32[31:0]     = 32'h00000018;
    abc64 = '0;
    abc64[1023:960] = 64'h6162638000000000;
    abc64[63:0]     = 64'h18;

    // SHA-256 "abc"
    send_block(abc32, 3'd2);
    wait_idle(el);
    check("s256_cycles", 64'(el), 64'd64);
    check("s256_idle_valid", 64'(w_valid), 64'd0);
    check("s256_W0", got[0], 64'h61626380);
    check("s256_W15", got[15], 64'h18);
    check("s256_W16", got[16], 64'h61626380);
    check("s256_W17", got[17], 64'h000F0000);

    // SHA-1 same block
    send_block(abc32, 3'd0);
    wait_idle(el);
    check("s1_cycles", 64'(el), 64'd80);
    check("s1_W16", got[16], 64'hC2C4C700);

    // SHA-512 "abc"
    send_block(abc64, 3'd4);
    wait_idle(el);
    check("s512_cycles", 64'(el), 64'd80);
    check("s512_W0", got[0], 64'h6162638000000000);
    check("s512_W16", got[16], 64'h6162638000000000);

    // SHA-224 random block
    rnd = {32{$urandom()}};
    send_block(rnd, 3'd1);
    wait_idle(el);

    // backpressure: stall 3 cycles at round 20
    rnd = {32{$urandom()}};
    send_block(rnd, 3'd2);
    wait_round(20);
    held    = w;
    w_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", 64'(w_valid), 64'd1);
      check("bp_w", w, held);
      check("bp_round", 64'(w_round), 64'd20);
    end
    @(posedge clk);
    #1 w_ready = 1'b1;
    wait_idle(el);

    // random backpressure on SHA-384
    rnd = {32{$urandom()}};
    send_block(rnd, 3'd3);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1 w_ready = ($urandom_range(0, 3) != 0);
      if (msg_ready && exp_q.size() == 0) break;
    end
    w_ready = 1'b1;
    wait_idle(el);

    // reset mid-block at round 30
    rnd = {32{$urandom()}};
    send_block(rnd, 3'd2);
    wait_round(30);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mrst_w_valid", 64'(w_valid), 64'd0);
    check("mrst_msg_ready", 64'(msg_ready), 64'd1);
    send_block(abc32, 3'd2);
    wait_idle(el);
    check("mrst_W0", got[0], 64'h61626380);
    check("mrst_W17", got[17], 64'h000F0000);

    // invalid mode is dropped with a one-cycle mode_err
    @(posedge clk);
    #1;
    msg       = {32{$urandom()}};
    mode      = mode_t'(3'd7);
    msg_valid = 1'b1;
    @(posedge clk);
    #1 msg_valid = 1'b0;
    @(negedge clk);
    check("bad_mode_err", 64'(mode_err), 64'd1);
    check("bad_w_valid", 64'(w_valid), 64'd0);
    check("bad_msg_ready", 64'(msg_ready), 64'd1);
    @(negedge clk);
    check("bad_mode_err_off", 64'(mode_err), 64'd0);
    check("bad_w_valid2", 64'(w_valid), 64'd0);
    check("bad_msg_ready2", 64'(msg_ready), 64'd1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sha_msg_schedule.md
Name: sha_msg_schedule

Overview:
- Message-schedule expander for the SHA core, directly downstream of the block padder.
- Accepts one 16-word message block (msg_t) plus mode_t per handshake.
- Emits the round words W_t one per cycle, t = 0..N-1, to the compression round stage.
- Uses the package delta0/delta1 functions for SHA-2 and a rotate-left-1 XOR recurrence for SHA-1.
- Holds a 16-word sliding window, so storage is constant regardless of round count.

Parameters:
- none; widths are fixed by the sha package (word_t 64 bit, msg_t 1024 bit).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- msg_valid  in  1  input block valid.
- msg_ready  out  1  block can be accepted (high only in IDLE).
- msg  in  1024 (sha::msg_t)  message block.
- mode  in  3 (sha::mode_t)  algorithm for this block; sampled with msg.
- w_valid  out  1  W_t valid.
- w_ready  in  1  downstream accepts W_t.
- w  out  64 (sha::word_t)  current round word; 32-bit modes zero-extended in w[63:32].
- w_round  out  7  current round index t.
- w_last  out  1  high when t = N-1.
- mode_err  out  1  one-cycle pulse when a block with an undefined mode is dropped.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, w_valid=0, w=0, w_round=0, w_last=0, mode_err=0; window cleared.
- msg_ready = (state==IDLE) & ~rst.
- Reset asserted mid-block aborts the block; the remaining words are never emitted.
- Word loading, 32-bit modes (sha1, sha224, sha256):
  - Uses msg[511:0]; word j = msg.w32[15-j], so word 0 = msg[511:480].
  - msg[1023:512] is ignored.
- Word loading, 64-bit modes (sha384, sha512): word j = msg.w64[15-j], so word 0 = msg[1023:960].
- Round count N: 80 for sha1, 64 for sha224/sha256, 80 for sha384/sha512.
- IDLE, on msg_valid & msg_ready:
  - mode in 0..4: load window R[0..15] = words 0..15, latch mode, round=0, go to RUN.
  - mode 5..7: drop the block, pulse mode_err next cycle, stay IDLE.
- RUN outputs:
  - w_valid=1, w=R[0], w_round=round, w_last=(round==N-1).
  - First W_0 appears the cycle after acceptance, i.e. latency 1.
- RUN, on w_valid & w_ready:
  - Shift R[i] <= R[i+1] for i = 0..14; round <= round+1.
  - Set R[15] <= next, computed from the current window (which holds W_t..W_t+15):
    - sha1: rotl1(R[13]^R[8]^R[2]^R[0]), 32-bit.
    - sha224/256: delta1_32(R[14]) + R[9] + delta0_32(R[1]) + R[0], mod 2^32.
    - sha384/512: delta1_64(R[14]) + R[9] + delta0_64(R[1]) + R[0], mod 2^64.
  - 32-bit results are stored with upper 32 bits zero.
  - Words past t=N-1 are computed but never emitted.
- Transfer of the word with w_last goes to IDLE; the next cycle has w_valid=0 and msg_ready=1.
- There is no overlap between blocks.
- Throughput with w_ready held high: accept cycle + N word cycles, i.e. 65 cycles per block for sha256 and 81 for sha512.
- Backpressure: while w_valid & ~w_ready, w, w_round, w_last and the window are held stable; there is no combinational path from w_ready to w.
- In RUN, msg_valid is ignored and msg_ready=0.
- mode is only sampled at acceptance; changes during RUN have no effect.

Test Plan:
- SHA-256, padded "abc" block (word0=0x61626380, word15=0x00000018, others 0), w_ready=1:
  - W_0=0x61626380, W_15=0x00000018, W_16=0x61626380, W_17=0x000F0000.
  - 64 words total; w_last only at t=63; msg_ready high again 65 cycles after accept.
- SHA-1, same 32-bit block:
  - W_16=0xC2C4C700.
  - 80 words; w_last at t=79; w[63:32]=0 throughout.
- SHA-512, "abc" block (w64 word0=0x6162638000000000, word15=0x18):
  - W_0=0x6162638000000000, W_16=0x6162638000000000.
  - 80 words; w_last at t=79.
- Backpressure: SHA-256 block, drop w_ready for 3 cycles when w_round=20:
  - w and w_round=20 held constant for those cycles.
  - Full sequence equals the no-stall golden model.
- Reset mid-block: assert rst for one cycle at w_round=30:
  - Next cycle w_valid=0 and msg_ready=1.
  - A new block is then accepted and starts from W_0.
- Invalid mode=7 with msg_valid=1:
  - mode_err pulses for exactly one cycle.
  - w_valid stays 0 and msg_ready stays 1.
